// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between two requesters (ALU, load) and the register-file write port.
// The arbiter uses the slave modport; the requester/register-file side uses master.
interface regfile_wb_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 64
);
    logic                  req0_valid;
    logic [ADDR_WIDTH-1:0] req0_addr;
    logic [DATA_WIDTH-1:0] req0_data;
    logic                  req0_ready;

    logic                  req1_valid;
    logic [ADDR_WIDTH-1:0] req1_addr;
    logic [DATA_WIDTH-1:0] req1_data;
    logic                  req1_ready;

    logic                  rf_write_en;
    logic [ADDR_WIDTH-1:0] rf_waddr;
    logic [DATA_WIDTH-1:0] rf_wdata;
    logic                  init_done;

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        output req0_ready,
        input  req1_valid, req1_addr, req1_data,
        output req1_ready,
        output rf_write_en, rf_waddr, rf_wdata, init_done
    );

    modport master (
        output req0_valid, req0_addr, req0_data,
        input  req0_ready,
        output req1_valid, req1_addr, req1_data,
        input  req1_ready,
        input  rf_write_en, rf_waddr, rf_wdata, init_done
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Clears every register-file entry after reset, then round-robin arbitrates two writeback
// requesters onto the single register-file write port with one cycle of latency.
module regfile_wb_arbiter #(
    parameter int unsigned NUM_REGS   = 16,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 64
) (
    input logic                clk,
    input logic                reset,
    regfile_wb_arbiter_if.slave bus
);
    localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(NUM_REGS - 1);

    typedef enum logic [0:0] {StInit, StArb} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    // 1 when requester 1 holds the most recent grant, so requester 0 wins the first contention.
    logic                  last_q, last_d;
    logic                  write_en_q, write_en_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  done_q, done_d;
    logic                  grant0, grant1;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_q == StArb) begin
            if (bus.req0_valid && bus.req1_valid) begin
                grant0 = last_q;
                grant1 = ~last_q;
            end else begin
                grant0 = bus.req0_valid;
                grant1 = bus.req1_valid;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        write_en_d = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        done_d     = done_q;
        unique case (state_q)
            StInit: begin
                write_en_d = 1'b1;
                waddr_d    = cnt_q;
                wdata_d    = '0;
                cnt_d      = cnt_q + 1'b1;
                if (cnt_q == LastAddr) begin
                    state_d = StArb;
                    done_d  = 1'b1;
                end
            end
            StArb: begin
                if (grant0) begin
                    write_en_d = 1'b1;
                    waddr_d    = bus.req0_addr;
                    wdata_d    = bus.req0_data;
                    last_d     = 1'b0;
                end else if (grant1) begin
                    write_en_d = 1'b1;
                    waddr_d    = bus.req1_addr;
                    wdata_d    = bus.req1_data;
                    last_d     = 1'b1;
                end
            end
            default: state_d = StInit;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StInit;
            cnt_q      <= '0;
            last_q     <= 1'b1;
            write_en_q <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            write_en_q <= write_en_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            done_q     <= done_d;
        end
    end

    assign bus.req0_ready  = grant0;
    assign bus.req1_ready  = grant1;
    assign bus.rf_write_en = write_en_q;
    assign bus.rf_waddr    = waddr_q;
    assign bus.rf_wdata    = wdata_q;
    assign bus.init_done   = done_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized and directed bench for regfile_wb_arbiter against a cycle-level behavioural model.
module tb_regfile_wb_arbiter;
    localparam int NUM_REGS = 16;
    localparam int AW = 4;
    localparam int DW = 64;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    regfile_wb_arbiter #(
        .NUM_REGS  (NUM_REGS),
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    // Model: number of clear writes issued, who won last, expected registered outputs.
    int          m_cnt;
    logic        m_done;
    int          m_last;
    logic        m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    logic        g0, g1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt  = 0;
        m_done = 1'b0;
        m_last = 1;
        m_we   = 1'b0;
        m_addr = '0;
        m_data = '0;
    endtask

    task automatic check_regs();
        check("write_en", 64'(bus.rf_write_en), 64'(m_we));
        check("waddr", 64'(bus.rf_waddr), 64'(m_addr));
        check("wdata", bus.rf_wdata, m_data);
        check("init_done", 64'(bus.init_done), 64'(m_done));
    endtask

    // Called just after a rising edge; applies inputs for the next cycle and checks it.
    task automatic step(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                        input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        bus.req0_valid = v0; bus.req0_addr = a0; bus.req0_data = d0;
        bus.req1_valid = v1; bus.req1_addr = a1; bus.req1_data = d1;
        #1;
        g0 = 1'b0;
        g1 = 1'b0;
        if (m_done) begin
            if (v0 && v1) begin
                g0 = (m_last == 1);
                g1 = (m_last == 0);
            end else begin
                g0 = v0;
                g1 = v1;
            end
        end
        check("req0_ready", 64'(bus.req0_ready), 64'(g0));
        check("req1_ready", 64'(bus.req1_ready), 64'(g1));
        @(posedge clk);
        if (!m_done) begin
            m_we   = 1'b1;
            m_addr = AW'(m_cnt);
            m_data = '0;
            m_cnt++;
            if (m_cnt == NUM_REGS) m_done = 1'b1;
        end else if (g0) begin
            m_we = 1'b1; m_addr = a0; m_data = d0; m_last = 0;
        end else if (g1) begin
            m_we = 1'b1; m_addr = a1; m_data = d1; m_last = 1;
        end else begin
            m_we = 1'b0;
        end
        #1;
        check_regs();
    endtask

    task automatic check_reset_outputs();
        check("rst_write_en", 64'(bus.rf_write_en), 64'd0);
        check("rst_waddr", 64'(bus.rf_waddr), 64'd0);
        check("rst_wdata", bus.rf_wdata, 64'd0);
        check("rst_init_done", 64'(bus.init_done), 64'd0);
        check("rst_ready0", 64'(bus.req0_ready), 64'd0);
        check("rst_ready1", 64'(bus.req1_ready), 64'd0);
    endtask

    logic          p0_v, p1_v;
    logic [AW-1:0] p0_a, p1_a;
    logic [DW-1:0] p0_d, p1_d;

    initial begin
        model_reset();
        bus.req0_valid = 1'b1; bus.req0_addr = 4'd5; bus.req0_data = 64'h1;
        bus.req1_valid = 1'b1; bus.req1_addr = 4'd5; bus.req1_data = 64'h2;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        reset = 1'b0;

        // Clear sequence with both valids held, then same-address contention.
        for (int i = 0; i < NUM_REGS; i++) step(1'b1, 4'd5, 64'h1, 1'b1, 4'd5, 64'h2);
        step(1'b1, 4'd5, 64'h1, 1'b1, 4'd5, 64'h2);
        check("first_contention_data", bus.rf_wdata, 64'h1);
        step(1'b0, 4'd0, 64'h0, 1'b1, 4'd5, 64'h2);
        check("second_write_data", bus.rf_wdata, 64'h2);

        // Continuous contention alternates grants.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 4'd1, 64'h11, 1'b1, 4'd2, 64'h22);
            check("rr_addr", 64'(bus.rf_waddr), (i % 2 == 0) ? 64'd1 : 64'd2);
        end

        // Single requester for one cycle, then idle.
        step(1'b1, 4'd3, 64'hDEAD_BEEF, 1'b0, 4'd0, 64'h0);
        check("single_addr", 64'(bus.rf_waddr), 64'd3);
        step(1'b0, 4'd3, 64'h0, 1'b0, 4'd0, 64'h0);
        check("idle_we", 64'(bus.rf_write_en), 64'd0);

        // Reset asserted mid-clear (counter = 7) restarts the sequence.
        reset = 1'b1;
        #1;
        check_reset_outputs();
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 7; i++) step(1'b1, 4'd9, 64'h9, 1'b1, 4'd8, 64'h8);
        reset = 1'b1;
        #1;
        check_reset_outputs();
        model_reset();
        @(posedge clk);
        #1;
        check_reset_outputs();
        reset = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            step(1'b1, 4'd9, 64'h9, 1'b0, 4'd8, 64'h8);
            check("restart_addr", 64'(bus.rf_waddr), 64'(i));
        end

        // Random traffic; an ungranted request stays stable until accepted.
        p0_v = 1'b0; p0_a = '0; p0_d = '0;
        p1_v = 1'b0; p1_a = '0; p1_d = '0;
        for (int i = 0; i < 400; i++) begin
            if (!p0_v && ($urandom_range(0, 1) == 1)) begin
                p0_v = 1'b1; p0_a = AW'($urandom); p0_d = {$urandom, $urandom};
            end
            if (!p1_v && ($urandom_range(0, 1) == 1)) begin
                p1_v = 1'b1; p1_a = AW'($urandom); p1_d = {$urandom, $urandom};
            end
            step(p0_v, p0_a, p0_d, p1_v, p1_a, p1_d);
            if (g0) p0_v = 1'b0;
            if (g1) p1_v = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
